regfile_2w_sb: RTL

REGFILE_2W_SB -- requirements
Module: regfile_2w_sb

---
 rtl/regfile_2w_sb_if.sv | 34 +++
 rtl/regfile_2w_sb.sv | 89 ++++++++
 2 files changed

// File: rtl/regfile_2w_sb_if.sv
// Port bundle for regfile_2w_sb: two write ports, two read ports, issue/flush and busy status.
// master drives writes/reads/issues; slave returns read data and busy flags.
interface regfile_2w_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic            we0;
    logic            we1;
    logic [AW-1:0]   wa0;
    logic [AW-1:0]   wa1;
    logic [XLEN-1:0] wd0;
    logic [XLEN-1:0] wd1;
    logic [AW-1:0]   ra1;
    logic [AW-1:0]   ra2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            iss_v;
    logic [AW-1:0]   iss_rd;
    logic            flush;
    logic            busy1;
    logic            busy2;

    modport master (
        output we0, we1, wa0, wa1, wd0, wd1, ra1, ra2, iss_v, iss_rd, flush,
        input  rd1, rd2, busy1, busy2
    );

    modport slave (
        input  we0, we1, wa0, wa1, wd0, wd1, ra1, ra2, iss_v, iss_rd, flush,
        output rd1, rd2, busy1, busy2
    );
endinterface

// File: rtl/regfile_2w_sb.sv
// 2-write/2-read register file (x0 hardwired to 0) with a per-register pending-write scoreboard.
// Latency: reads and busy are combinational, writes land on the rising edge; no backpressure.
// Optional REGFILE_BYPASS_EN forwards same-cycle write data and write-cleared busy to the read ports.
module regfile_2w_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic           clk,
    input  logic           reset,
    regfile_2w_sb_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  rf [NREGS];
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_nxt;
    logic             wr0_en;
    logic             wr1_en;
    logic [XLEN-1:0]  rd1_dat;
    logic [XLEN-1:0]  rd2_dat;
    logic             busy1_int;
    logic             busy2_int;

    assign wr0_en = bus.we0 && (bus.wa0 != '0);
    assign wr1_en = bus.we1 && (bus.wa1 != '0);

    // The issue is applied after the write clears: a same-cycle issue is the newer producer.
    always_comb begin
        pending_nxt = pending;
        if (wr0_en) pending_nxt[bus.wa0] = 1'b0;
        if (wr1_en) pending_nxt[bus.wa1] = 1'b0;
        if (bus.flush)
            pending_nxt = '0;
        else if (bus.iss_v && (bus.iss_rd != '0))
            pending_nxt[bus.iss_rd] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
            pending <= '0;
        end else begin
            pending <= pending_nxt;
            if (wr0_en) rf[bus.wa0] <= bus.wd0;
            if (wr1_en) rf[bus.wa1] <= bus.wd1;
        end
    end

    always_comb begin
        rd1_dat   = rf[bus.ra1];
        busy1_int = pending[bus.ra1];
`ifdef REGFILE_BYPASS_EN
        if (wr1_en && (bus.wa1 == bus.ra1))
            rd1_dat = bus.wd1;
        else if (wr0_en && (bus.wa0 == bus.ra1))
            rd1_dat = bus.wd0;
        if (((wr1_en && (bus.wa1 == bus.ra1)) || (wr0_en && (bus.wa0 == bus.ra1))) &&
            !(bus.iss_v && (bus.iss_rd == bus.ra1)))
            busy1_int = 1'b0;
`endif
        if (reset || (bus.ra1 == '0)) begin
            rd1_dat   = '0;
            busy1_int = 1'b0;
        end
    end

    always_comb begin
        rd2_dat   = rf[bus.ra2];
        busy2_int = pending[bus.ra2];
`ifdef REGFILE_BYPASS_EN
        if (wr1_en && (bus.wa1 == bus.ra2))
            rd2_dat = bus.wd1;
        else if (wr0_en && (bus.wa0 == bus.ra2))
            rd2_dat = bus.wd0;
        if (((wr1_en && (bus.wa1 == bus.ra2)) || (wr0_en && (bus.wa0 == bus.ra2))) &&
            !(bus.iss_v && (bus.iss_rd == bus.ra2)))
            busy2_int = 1'b0;
`endif
        if (reset || (bus.ra2 == '0)) begin
            rd2_dat   = '0;
            busy2_int = 1'b0;
        end
    end

    assign bus.rd1   = rd1_dat;
    assign bus.rd2   = rd2_dat;
    assign bus.busy1 = busy1_int;
    assign bus.busy2 = busy2_int;
endmodule
